// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the N-channel DDR3 write arbiter.
// Watermark priority is enabled by defining MEM_ARB_WATERMARK_PRIO_EN.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      BURST = 2'd2
   } arb_state_t;

   localparam logic [2:0] APP_CMD_WRITE = 3'b000;
   localparam logic [2:0] APP_CMD_READ  = 3'b001;

endpackage

// File: rtl/mem_write_arbiter_n_rr_select.sv
// Round-robin selector: first asserted request at or after the pointer, wrapping.
// Produces both a one-hot grant and the matching channel index.
module rr_select #(
   parameter int NUM_CH = 4,
   parameter int PTR_W  = 2
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [PTR_W-1:0]  ptr,
   output logic [NUM_CH-1:0] grant,
   output logic [PTR_W-1:0]  index,
   output logic              valid
);

   always_comb begin
      int idx;
      grant = '0;
      index = '0;
      valid = 1'b0;
      idx   = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = (int'(ptr) + i) % NUM_CH;
         if (!valid && req[idx]) begin
            valid      = 1'b1;
            grant[idx] = 1'b1;
            index      = PTR_W'(idx);
         end
      end
   end

endmodule

// File: rtl/mem_write_arbiter_n.sv
// Round-robin write arbiter from NUM_CH capture FIFO pairs into the MIG app_* write port.
// Define MEM_ARB_WATERMARK_PRIO_EN to let channels at/above HIGH_WATER win arbitration first.
module mem_write_arbiter_n
   import mem_arb_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 29,
   parameter int BURST_LEN  = 8,
   parameter int ADDR_STEP  = 8,
   parameter int HIGH_WATER = 256
) (
   input  logic                         clk_ram,
   input  logic                         rst_n,
   input  logic                         soft_rst,
   input  logic                         flush_req,
   output logic                         flush_done,
   output logic [NUM_CH-1:0]            addr_rd_en,
   input  logic [NUM_CH*ADDR_WIDTH-1:0] addr_rd_data,
   input  logic [NUM_CH*8-1:0]          addr_rd_size,
   output logic [NUM_CH-1:0]            data_rd_en,
   input  logic [NUM_CH*DATA_WIDTH-1:0] data_rd_data,
   input  logic [NUM_CH*10-1:0]         data_rd_size,
   output logic                         app_en,
   output logic [2:0]                   app_cmd,
   output logic [ADDR_WIDTH-1:0]        app_addr,
   input  logic                         app_rdy,
   output logic                         app_wdf_wren,
   output logic                         app_wdf_end,
   output logic [DATA_WIDTH-1:0]        app_wdf_data,
   output logic [DATA_WIDTH/8-1:0]      app_wdf_mask,
   input  logic                         app_wdf_rdy
);

   localparam int PTR_W = $clog2(NUM_CH);
   localparam int CNT_W = $clog2(BURST_LEN) + 1;
   localparam logic [CNT_W-1:0] BL = CNT_W'(BURST_LEN);

   arb_state_t                state;
   logic [PTR_W-1:0]          rr_ptr;
   logic [PTR_W-1:0]          sel_idx;
   logic [NUM_CH-1:0]         sel_oh;
   logic [ADDR_WIDTH-1:0]     base;
   logic [CNT_W-1:0]          cmd_cnt;
   logic [CNT_W-1:0]          data_cnt;
   logic [CNT_W-1:0]          cmd_nxt;
   logic [CNT_W-1:0]          data_nxt;

   logic [NUM_CH-1:0]         eligible;
   logic [ADDR_WIDTH-1:0]     addr_ch [NUM_CH];
   logic [DATA_WIDTH-1:0]     data_ch [NUM_CH];

   logic [NUM_CH-1:0]         rr_grant;
   logic [PTR_W-1:0]          rr_index;
   logic                      rr_valid;
   logic [NUM_CH-1:0]         pick_grant;
   logic [PTR_W-1:0]          pick_index;
   logic                      pick_valid;

   // A channel may only be granted once a whole burst of data is already queued.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         eligible[i] = (addr_rd_size[i*8 +: 8] != 8'd0) &&
                       (data_rd_size[i*10 +: 10] >= 10'(BURST_LEN));
         addr_ch[i]  = addr_rd_data[i*ADDR_WIDTH +: ADDR_WIDTH];
         data_ch[i]  = data_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   rr_select #(.NUM_CH(NUM_CH), .PTR_W(PTR_W)) u_rr_select (
      .req   (eligible),
      .ptr   (rr_ptr),
      .grant (rr_grant),
      .index (rr_index),
      .valid (rr_valid)
   );

`ifdef MEM_ARB_WATERMARK_PRIO_EN
   logic [NUM_CH-1:0] hw_req;
   logic [NUM_CH-1:0] hw_grant;
   logic [PTR_W-1:0]  hw_index;
   logic              hw_valid;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         hw_req[i] = eligible[i] && (data_rd_size[i*10 +: 10] >= 10'(HIGH_WATER));
      end
   end

   rr_select #(.NUM_CH(NUM_CH), .PTR_W(PTR_W)) u_hw_select (
      .req   (hw_req),
      .ptr   (rr_ptr),
      .grant (hw_grant),
      .index (hw_index),
      .valid (hw_valid)
   );

   assign pick_grant = hw_valid ? hw_grant : rr_grant;
   assign pick_index = hw_valid ? hw_index : rr_index;
   assign pick_valid = rr_valid;
`else
   assign pick_grant = rr_grant;
   assign pick_index = rr_index;
   assign pick_valid = rr_valid;
`endif

   assign app_en       = (state == BURST) && (cmd_cnt < BL);
   assign app_wdf_wren = (state == BURST) && (data_cnt < BL);
   assign app_wdf_end  = app_wdf_wren;
   assign app_addr     = app_en ? base + ADDR_WIDTH'(cmd_cnt) * ADDR_WIDTH'(ADDR_STEP) : '0;
   assign app_wdf_data = app_wdf_wren ? data_ch[sel_idx] : '0;
   assign app_cmd      = APP_CMD_WRITE;
   assign app_wdf_mask = '0;

   // soft_rst also resets the client FIFOs, so no pop may be issued alongside it.
   assign addr_rd_en = ((state == GRANT) && !soft_rst) ? sel_oh : '0;
   assign data_rd_en = (app_wdf_wren && app_wdf_rdy && !soft_rst) ? sel_oh : '0;
   assign flush_done = flush_req && (state == IDLE) && (addr_rd_size == '0);

   assign cmd_nxt  = cmd_cnt + CNT_W'(app_en && app_rdy);
   assign data_nxt = data_cnt + CNT_W'(app_wdf_wren && app_wdf_rdy);

   // Command and data counters run independently; the burst ends once both reach BURST_LEN.
   always_ff @(posedge clk_ram or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         sel_idx  <= '0;
         sel_oh   <= '0;
         base     <= '0;
         cmd_cnt  <= '0;
         data_cnt <= '0;
      end else if (soft_rst) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         sel_oh   <= '0;
         cmd_cnt  <= '0;
         data_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  state   <= GRANT;
                  sel_idx <= pick_index;
                  sel_oh  <= pick_grant;
               end
            end
            GRANT: begin
               base     <= addr_ch[sel_idx];
               cmd_cnt  <= '0;
               data_cnt <= '0;
               state    <= BURST;
            end
            BURST: begin
               cmd_cnt  <= cmd_nxt;
               data_cnt <= data_nxt;
               if ((cmd_nxt == BL) && (data_nxt == BL)) begin
                  state  <= IDLE;
                  rr_ptr <= (sel_idx == PTR_W'(NUM_CH - 1)) ? '0 : sel_idx + PTR_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_write_arbiter_n.sv
// Self-checking bench for mem_write_arbiter_n: FIFO models, a round-robin burst plan and a per-cycle checker.
// Honours MEM_ARB_WATERMARK_PRIO_EN in both the model and the directed priority case.
module tb_mem_write_arbiter_n;

   localparam int NUM_CH = 4;
   localparam int DW     = 256;
   localparam int AW     = 29;
   localparam int BL     = 8;
   localparam int STEP   = 8;
   localparam int HW     = 256;

   logic                  clk_ram = 1'b0;
   logic                  rst_n, soft_rst, flush_req, flush_done;
   logic [NUM_CH-1:0]     addr_rd_en, data_rd_en;
   logic [NUM_CH*AW-1:0]  addr_rd_data;
   logic [NUM_CH*8-1:0]   addr_rd_size;
   logic [NUM_CH*DW-1:0]  data_rd_data;
   logic [NUM_CH*10-1:0]  data_rd_size;
   logic                  app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy;
   logic [2:0]            app_cmd;
   logic [AW-1:0]         app_addr;
   logic [DW-1:0]         app_wdf_data;
   logic [DW/8-1:0]       app_wdf_mask;

   always #5 clk_ram = ~clk_ram;

   mem_write_arbiter_n #(
      .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
      .BURST_LEN(BL), .ADDR_STEP(STEP), .HIGH_WATER(HW)
   ) dut (
      .clk_ram(clk_ram), .rst_n(rst_n), .soft_rst(soft_rst),
      .flush_req(flush_req), .flush_done(flush_done),
      .addr_rd_en(addr_rd_en), .addr_rd_data(addr_rd_data), .addr_rd_size(addr_rd_size),
      .data_rd_en(data_rd_en), .data_rd_data(data_rd_data), .data_rd_size(data_rd_size),
      .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
      .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_data(app_wdf_data),
      .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy)
   );

   // Client FIFO contents and the expected burst sequence
   logic [AW-1:0] aq [NUM_CH][$];
   logic [DW-1:0] dq [NUM_CH][$];
   int            plan_ch[$];
   logic [AW-1:0] plan_base[$];
   int            grant_log[$];
   logic [AW-1:0] cmd_log[$];

   int checks = 0;
   int failures = 0;
   int model_rr = 0;
   int rdy_mode = 0;
   int t3_cyc = 0;
   int beat_total = 0;
   int bursts_done = 0;
   bit active = 0;
   int cur_ch = 0;
   logic [AW-1:0] cur_base = '0;
   int cmd_k = 0;
   int beat_k = 0;
   bit abort_cycle = 0;
   bit clear_fifos = 0;
   logic [NUM_CH-1:0] pend_a = '0;
   logic [NUM_CH-1:0] pend_d = '0;
   bit prev_cmd_wait = 0;
   bit prev_wdf_wait = 0;
   logic [AW-1:0] prev_addr = '0;
   logic [DW-1:0] prev_data = '0;

   task automatic check_output(input bit ok, input string name,
                               input logic [DW-1:0] act, input logic [DW-1:0] req);
      checks++;
      if (!ok) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic int oh_index(input logic [NUM_CH-1:0] v);
      for (int i = 0; i < NUM_CH; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic refresh();
      for (int c = 0; c < NUM_CH; c++) begin
         addr_rd_data[c*AW +: AW] = (aq[c].size() != 0) ? aq[c][0] : '0;
         data_rd_data[c*DW +: DW] = (dq[c].size() != 0) ? dq[c][0] : '0;
         addr_rd_size[c*8 +: 8]   = (aq[c].size() > 255) ? 8'hFF : 8'(aq[c].size());
         data_rd_size[c*10 +: 10] = (dq[c].size() > 1023) ? 10'h3FF : 10'(dq[c].size());
      end
   endtask

   task automatic apply_stimulus(input int ch, input bit with_addr, input logic [AW-1:0] base,
                                 input int beats);
      logic [DW-1:0] d;
      if (with_addr) aq[ch].push_back(base);
      for (int b = 0; b < beats; b++) begin
         for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = $urandom;
         dq[ch].push_back(d);
      end
      refresh();
   endtask

   // Replays round-robin arbitration over the queued entries to get the burst order.
   task automatic build_plan();
      int ac[NUM_CH];
      int dc[NUM_CH];
      int used[NUM_CH];
      int rr, pick;
      bit stop;
      rr = model_rr;
      stop = 0;
      for (int c = 0; c < NUM_CH; c++) begin
         ac[c] = aq[c].size(); dc[c] = dq[c].size(); used[c] = 0;
      end
      for (int it = 0; it < 4096 && !stop; it++) begin
         pick = -1;
`ifdef MEM_ARB_WATERMARK_PRIO_EN
         for (int k = 0; k < NUM_CH; k++) begin
            int c = (rr + k) % NUM_CH;
            if (pick < 0 && ac[c] > 0 && dc[c] >= BL && dc[c] >= HW) pick = c;
         end
`endif
         for (int k = 0; k < NUM_CH; k++) begin
            int c = (rr + k) % NUM_CH;
            if (pick < 0 && ac[c] > 0 && dc[c] >= BL) pick = c;
         end
         if (pick < 0) stop = 1;
         else begin
            plan_ch.push_back(pick);
            plan_base.push_back(aq[pick][used[pick]]);
            used[pick]++; ac[pick]--; dc[pick] -= BL;
            rr = (pick + 1) % NUM_CH;
         end
      end
      model_rr = rr;
   endtask

   task automatic advance();
      @(posedge clk_ram);
      #1;
      for (int c = 0; c < NUM_CH; c++) begin
         if (pend_a[c] && aq[c].size() != 0) void'(aq[c].pop_front());
         if (pend_d[c] && dq[c].size() != 0) void'(dq[c].pop_front());
      end
      if (clear_fifos) begin
         for (int c = 0; c < NUM_CH; c++) begin aq[c].delete(); dq[c].delete(); end
         plan_ch.delete(); plan_base.delete();
         active = 0; clear_fifos = 0;
      end
      case (rdy_mode)
         1: begin app_rdy = ($urandom_range(0, 3) != 0); app_wdf_rdy = ($urandom_range(0, 3) != 0); end
         2: begin app_rdy = !(t3_cyc >= 4 && t3_cyc < 9); app_wdf_rdy = t3_cyc[0]; t3_cyc++; end
         default: begin app_rdy = 1'b1; app_wdf_rdy = 1'b1; end
      endcase
      refresh();
   endtask

   task automatic sample();
      int c;
      bit busy, exp_fd, all_empty;
      logic [AW-1:0] exp_addr;
      @(negedge clk_ram);
      pend_a = addr_rd_en;
      pend_d = data_rd_en;
      if (!rst_n) begin
         check_output(!app_en && !app_wdf_wren && !app_wdf_end && addr_rd_en == 0 && data_rd_en == 0 &&
                      !flush_done && app_addr == 0 && app_wdf_data == 0 && app_cmd == 0 && app_wdf_mask == 0,
                      "reset_outputs", {app_en, app_wdf_wren, addr_rd_en, data_rd_en, flush_done, app_addr}, 0);
         return;
      end
      check_output(app_cmd == 3'b000 && app_wdf_mask == 0, "cmd_mask", {app_cmd, app_wdf_mask}, 0);
      check_output(app_wdf_end == app_wdf_wren, "wdf_end", DW'(app_wdf_end), DW'(app_wdf_wren));
      check_output($countones(addr_rd_en) <= 1 && $countones(data_rd_en) <= 1, "single_pop",
                   {addr_rd_en, data_rd_en}, 0);
      for (int i = 0; i < NUM_CH; i++) begin
         if (addr_rd_en[i]) check_output(aq[i].size() != 0, "addr_pop_empty", DW'(i), 0);
         if (data_rd_en[i]) check_output(dq[i].size() != 0, "data_pop_empty", DW'(i), 0);
      end
      if (abort_cycle) begin
         check_output(addr_rd_en == 0 && data_rd_en == 0, "abort_no_pop", {addr_rd_en, data_rd_en}, 0);
         prev_cmd_wait = 0;
         prev_wdf_wait = 0;
         return;
      end
      if (prev_cmd_wait)
         check_output(app_en && app_addr == prev_addr, "cmd_hold", {app_en, app_addr}, {1'b1, prev_addr});
      if (prev_wdf_wait)
         check_output(app_wdf_wren && app_wdf_data == prev_data, "wdf_hold", app_wdf_data, prev_data);
      busy = active;
      if (addr_rd_en != 0) begin
         c = oh_index(addr_rd_en);
         busy = 1;
         grant_log.push_back(c);
         if (active || plan_ch.size() == 0) check_output(0, "unexpected_grant", DW'(c), '1);
         else begin
            check_output(c == plan_ch[0], "grant_channel", DW'(c), DW'(plan_ch[0]));
            active = 1; cur_ch = plan_ch[0]; cur_base = plan_base[0]; cmd_k = 0; beat_k = 0;
         end
      end
      if (app_en && app_rdy) begin
         if (!active || cmd_k >= BL) check_output(0, "unexpected_cmd", DW'(app_addr), 0);
         else begin
            exp_addr = cur_base + AW'(cmd_k * STEP);
            check_output(app_addr == exp_addr, "cmd_addr", DW'(app_addr), DW'(exp_addr));
            cmd_log.push_back(app_addr);
            cmd_k++;
         end
      end
      if (app_wdf_wren && app_wdf_rdy) begin
         if (!active || beat_k >= BL) check_output(0, "unexpected_beat", app_wdf_data, 0);
         else begin
            check_output(data_rd_en == (NUM_CH'(1) << cur_ch), "data_pop_channel",
                         DW'(data_rd_en), DW'(NUM_CH'(1) << cur_ch));
            check_output(dq[cur_ch].size() != 0 && app_wdf_data == dq[cur_ch][0], "beat_data",
                         app_wdf_data, (dq[cur_ch].size() != 0) ? dq[cur_ch][0] : '0);
            beat_k++;
            beat_total++;
         end
      end else begin
         check_output(data_rd_en == 0, "data_pop_no_beat", DW'(data_rd_en), 0);
      end
      if (active && cmd_k == BL && beat_k == BL) begin
         void'(plan_ch.pop_front());
         void'(plan_base.pop_front());
         active = 0;
         bursts_done++;
      end
      all_empty = 1;
      for (int i = 0; i < NUM_CH; i++) if (aq[i].size() != 0) all_empty = 0;
      exp_fd = flush_req && !busy && all_empty;
      check_output(flush_done == exp_fd, "flush_done", DW'(flush_done), DW'(exp_fd));
      prev_cmd_wait = app_en && !app_rdy;
      prev_addr     = app_addr;
      prev_wdf_wait = app_wdf_wren && !app_wdf_rdy;
      prev_data     = app_wdf_data;
   endtask

   task automatic cycle();
      advance();
      sample();
   endtask

   task automatic run_until_idle(input int maxc);
      int n = 0;
      while ((plan_ch.size() != 0 || active) && n < maxc) begin
         cycle();
         n++;
      end
      check_output(plan_ch.size() == 0 && !active, "drain_timeout", DW'(plan_ch.size()), 0);
      cycle();
      cycle();
   endtask

   task automatic do_soft_rst();
      advance();
      soft_rst = 1'b1;
      abort_cycle = 1;
      sample();
      abort_cycle = 0;
      clear_fifos = 1;
      advance();
      soft_rst = 1'b0;
      model_rr = 0;
      sample();
      check_output(!app_en && !app_wdf_wren, "post_abort_idle", {app_en, app_wdf_wren}, 0);
   endtask

   initial begin
      #900000;
      $display("[TB] FAIL watchdog expired actual=running required=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int b0, g0, d0, n;
      int exp_order[8];
      rst_n = 1'b0; soft_rst = 1'b0; flush_req = 1'b0;
      app_rdy = 1'b0; app_wdf_rdy = 1'b0;
      refresh();
      sample();
      sample();
      rst_n = 1'b1;
      cycle();

      // Single channel, single burst, always-ready controller
      cmd_log.delete();
      b0 = beat_total;
      apply_stimulus(0, 1, 29'h100, 8);
      build_plan();
      run_until_idle(200);
      check_output(cmd_log.size() == 8, "t1_cmd_count", DW'(cmd_log.size()), 8);
      check_output(cmd_log.size() > 0 && cmd_log[0] == 29'h100, "t1_first_addr",
                   (cmd_log.size() > 0) ? DW'(cmd_log[0]) : '0, 'h100);
      check_output(cmd_log.size() > 7 && cmd_log[7] == 29'h138, "t1_last_addr",
                   (cmd_log.size() > 7) ? DW'(cmd_log[7]) : '0, 'h138);
      check_output(beat_total - b0 == 8, "t1_beats", DW'(beat_total - b0), 8);

      // All four channels eligible, two bursts each, from rr pointer 0
      do_soft_rst();
      g0 = grant_log.size();
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < NUM_CH; c++)
            apply_stimulus(c, 1, (c == 3 && r == 1) ? 29'h1FFF_FFF0 : AW'(32'h1000 * (c + 1) + 32'h200 * r), 8);
      build_plan();
      run_until_idle(400);
      exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
      for (int i = 0; i < 8; i++)
         check_output(grant_log.size() > g0 + i && grant_log[g0 + i] == exp_order[i], "t2_order",
                      (grant_log.size() > g0 + i) ? DW'(grant_log[g0 + i]) : '1, DW'(exp_order[i]));

      // Controller stalls mid-burst while wdf_rdy toggles
      rdy_mode = 2;
      t3_cyc = 0;
      b0 = beat_total;
      cmd_log.delete();
      apply_stimulus(2, 1, 29'h4000, 8);
      build_plan();
      run_until_idle(200);
      check_output(cmd_log.size() == 8, "t3_cmd_count", DW'(cmd_log.size()), 8);
      check_output(beat_total - b0 == 8, "t3_beats", DW'(beat_total - b0), 8);
      rdy_mode = 0;

      // Seven beats are not enough to grant; the eighth makes the channel eligible
      g0 = grant_log.size();
      apply_stimulus(1, 1, 29'h5000, 7);
      build_plan();
      for (int i = 0; i < 20; i++) cycle();
      check_output(grant_log.size() == g0, "t4_no_grant", DW'(grant_log.size() - g0), 0);
      apply_stimulus(1, 0, '0, 1);
      build_plan();
      run_until_idle(200);
      check_output(grant_log.size() == g0 + 1 && grant_log[g0] == 1, "t4_grant",
                   (grant_log.size() > g0) ? DW'(grant_log[g0]) : '1, 1);

      // Randomised traffic with random back-pressure
      rdy_mode = 1;
      for (int ph = 0; ph < 6; ph++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            n = $urandom_range(0, 2);
            for (int b = 0; b < n; b++) apply_stimulus(c, 1, AW'($urandom), 8);
            if ($urandom_range(0, 4) == 0) apply_stimulus(c, 1, AW'($urandom), $urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) apply_stimulus(c, 0, '0, $urandom_range(1, 8));
         end
         build_plan();
         run_until_idle(3000);
      end

      // Flush with three pending bursts
      do_soft_rst();
      d0 = bursts_done;
      apply_stimulus(0, 1, 29'h6000, 8);
      apply_stimulus(1, 1, 29'h7000, 8);
      apply_stimulus(2, 1, 29'h8000, 8);
      flush_req = 1'b1;
      build_plan();
      run_until_idle(600);
      check_output(bursts_done - d0 == 3, "t5_bursts", DW'(bursts_done - d0), 3);
      check_output(flush_done == 1'b1, "t5_flush_done", DW'(flush_done), 1);
      flush_req = 1'b0;
      cycle();
      check_output(flush_done == 1'b0, "t5_flush_drop", DW'(flush_done), 0);

      // soft_rst in the middle of a burst
      rdy_mode = 0;
      apply_stimulus(3, 1, 29'h9000, 8);
      build_plan();
      n = 0;
      while (!(active && cmd_k >= 3) && n < 50) begin
         cycle();
         n++;
      end
      check_output(active && cmd_k >= 3, "t5_midburst_reached", DW'(cmd_k), 3);
      do_soft_rst();

`ifdef MEM_ARB_WATERMARK_PRIO_EN
      // A channel at the high-water mark wins over the round-robin choice
      g0 = grant_log.size();
      apply_stimulus(0, 1, 29'hA000, 8);
      apply_stimulus(3, 1, 29'hB000, HW);
      build_plan();
      check_output(plan_ch.size() > 0 && plan_ch[0] == 3, "t6_model_first", DW'(plan_ch[0]), 3);
      run_until_idle(400);
      check_output(grant_log.size() > g0 && grant_log[g0] == 3, "t6_first_grant",
                   (grant_log.size() > g0) ? DW'(grant_log[g0]) : '1, 3);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
